// File: rtl/pu_requant_pkg.sv
// pu_requant_pkg: shared states and parameter-word layout for the requant sequencer
package pu_requant_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_RUN, S_DONE} state_t;
  localparam int OC_PER_GRP = 4;
  localparam int OC0 = 0;
  localparam int OC1 = 1;
  localparam int OC2 = 2;
  localparam int OC3 = 3;
  function automatic int parm_lsb(input int oc, input int wd);
    return oc * wd;
  endfunction
endpackage

// File: rtl/pu_requant_ctrl.sv
// pu_requant_ctrl: walks oc groups, fetches their requant params and gates upstream rows into the requant pipe
module pu_requant_ctrl
  import pu_requant_pkg::*;
#(
  parameter int REQUANT_PARM_WD = 8,
  parameter int GRP_CNT_WD      = 8,
  parameter int ROW_CNT_WD      = 8,
  parameter int PARM_ADDR_WD    = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_start_i,
  input  logic                                  cfg_abort_i,
  input  logic [GRP_CNT_WD-1:0]                 cfg_grp_num_i,
  input  logic [ROW_CNT_WD-1:0]                 cfg_row_num_i,
  input  logic [PARM_ADDR_WD-1:0]               cfg_parm_base_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  parm_rd_en_o,
  output logic [PARM_ADDR_WD-1:0]               parm_rd_addr_o,
  input  logic [OC_PER_GRP*REQUANT_PARM_WD-1:0] parm_rd_data_i,
  input  logic                                  up_vld_i,
  output logic                                  up_rdy_o,
  output logic                                  p4_vld_o,
  input  logic                                  p4_rdy_i,
  output logic [REQUANT_PARM_WD-1:0]            parm_oc0_o,
  output logic [REQUANT_PARM_WD-1:0]            parm_oc1_o,
  output logic [REQUANT_PARM_WD-1:0]            parm_oc2_o,
  output logic [REQUANT_PARM_WD-1:0]            parm_oc3_o,
  output logic [GRP_CNT_WD-1:0]                 grp_idx_o,
  output logic [ROW_CNT_WD-1:0]                 row_idx_o
);
  state_t                                state;
  logic [GRP_CNT_WD-1:0]                 grp_num_q;
  logic [ROW_CNT_WD-1:0]                 row_num_q;
  logic [PARM_ADDR_WD-1:0]               base_q;
  logic [OC_PER_GRP*REQUANT_PARM_WD-1:0] parm_q;
  logic                                  run;
  logic                                  hs;
  logic                                  last_row;
  logic                                  last_grp;
  always_comb begin
    run      = state == S_RUN;
    hs       = run & up_vld_i & p4_rdy_i;
    last_row = row_idx_o == row_num_q - ROW_CNT_WD'(1);
    last_grp = grp_idx_o == grp_num_q - GRP_CNT_WD'(1);
  end
  assign p4_vld_o       = run & up_vld_i;
  assign up_rdy_o       = run & p4_rdy_i;
  assign parm_rd_addr_o = base_q + PARM_ADDR_WD'(grp_idx_o);
  assign parm_oc0_o     = parm_q[parm_lsb(OC0, REQUANT_PARM_WD) +: REQUANT_PARM_WD];
  assign parm_oc1_o     = parm_q[parm_lsb(OC1, REQUANT_PARM_WD) +: REQUANT_PARM_WD];
  assign parm_oc2_o     = parm_q[parm_lsb(OC2, REQUANT_PARM_WD) +: REQUANT_PARM_WD];
  assign parm_oc3_o     = parm_q[parm_lsb(OC3, REQUANT_PARM_WD) +: REQUANT_PARM_WD];
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      parm_rd_en_o <= 1'b0;
      grp_num_q    <= '0;
      row_num_q    <= '0;
      base_q       <= '0;
      parm_q       <= '0;
      grp_idx_o    <= '0;
      row_idx_o    <= '0;
    end else if (cfg_abort_i && state != S_IDLE) begin
      state        <= S_IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      parm_rd_en_o <= 1'b0;
      grp_idx_o    <= '0;
      row_idx_o    <= '0;
    end else begin
      case (state)
        S_IDLE: if (cfg_start_i) begin
          grp_num_q <= cfg_grp_num_i;
          row_num_q <= cfg_row_num_i;
          base_q    <= cfg_parm_base_i;
          grp_idx_o <= '0;
          row_idx_o <= '0;
          busy_o    <= 1'b1;
          if (cfg_grp_num_i == '0 || cfg_row_num_i == '0) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            state        <= S_FETCH;
            parm_rd_en_o <= 1'b1;
          end
        end
        S_FETCH: begin
          parm_rd_en_o <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          parm_q <= parm_rd_data_i;
          state  <= S_RUN;
        end
        S_RUN: if (hs) begin
          row_idx_o <= last_row ? '0 : row_idx_o + ROW_CNT_WD'(1);
          if (last_row && last_grp) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else if (last_row) begin
            grp_idx_o    <= grp_idx_o + GRP_CNT_WD'(1);
            state        <= S_FETCH;
            parm_rd_en_o <= 1'b1;
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pu_requant_ctrl.sv
// tb_pu_requant_ctrl: directed self-checking bench for the requant sequencer
module tb_pu_requant_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  g = '0;
  logic [7:0]  r = '0;
  logic [9:0]  base = '0;
  logic        busy_o, done_o, parm_rd_en_o, up_rdy_o, p4_vld_o;
  logic [9:0]  parm_rd_addr_o;
  logic [31:0] rd_data;
  logic        up_vld = 1'b0;
  logic        p4_rdy = 1'b0;
  logic [7:0]  oc0, oc1, oc2, oc3, grp_idx_o, row_idx_o;
  logic [31:0] parm_bus;
  logic [31:0] mem [1024];
  logic [31:0] exp_w [4];
  logic [9:0]  rd_q [$];
  int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0;
  int hs_cnt = 0, done_cnt = 0, vld_cnt = 0, done_cyc = 0;
  int hs_base = 0, done_base = 0, vld_base = 0, rd_base = 0, cur_r = 1;
  pu_requant_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start_i(start), .cfg_abort_i(abort),
    .cfg_grp_num_i(g), .cfg_row_num_i(r), .cfg_parm_base_i(base),
    .busy_o(busy_o), .done_o(done_o), .parm_rd_en_o(parm_rd_en_o),
    .parm_rd_addr_o(parm_rd_addr_o), .parm_rd_data_i(rd_data),
    .up_vld_i(up_vld), .up_rdy_o(up_rdy_o), .p4_vld_o(p4_vld_o), .p4_rdy_i(p4_rdy),
    .parm_oc0_o(oc0), .parm_oc1_o(oc1), .parm_oc2_o(oc2), .parm_oc3_o(oc3),
    .grp_idx_o(grp_idx_o), .row_idx_o(row_idx_o)
  );
  assign parm_bus = {oc3, oc2, oc1, oc0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (parm_rd_en_o) rd_data <= mem[parm_rd_addr_o];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (up_vld && up_rdy_o) begin
      check("hs_parm", parm_bus, exp_w[((hs_cnt - hs_base) / cur_r) % 4]);
      hs_cnt++;
    end
    if (p4_vld_o) vld_cnt++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
    if (parm_rd_en_o) rd_q.push_back(parm_rd_addr_o);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_layer(input logic [7:0] gn, input logic [7:0] rn, input logic [9:0] b);
    g = gn;
    r = rn;
    base = b;
    cur_r = (rn == 0) ? 1 : int'(rn);
    hs_base = hs_cnt;
    done_base = done_cnt;
    vld_base = vld_cnt;
    rd_base = rd_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc - 1;
    g = 8'hFF;
    r = 8'hFF;
    base = 10'h155;
  endtask
  task automatic wait_done(input int max);
    int i = 0;
    while (done_cnt == done_base && i < max) begin
      tick();
      i++;
    end
  endtask
  task automatic chk_reset(input string p);
    check({p, "_busy"}, busy_o, 0);
    check({p, "_done"}, done_o, 0);
    check({p, "_rd_en"}, parm_rd_en_o, 0);
    check({p, "_addr"}, parm_rd_addr_o, 0);
    check({p, "_p4_vld"}, p4_vld_o, 0);
    check({p, "_up_rdy"}, up_rdy_o, 0);
    check({p, "_parm"}, parm_bus, 0);
    check({p, "_grp"}, grp_idx_o, 0);
    check({p, "_row"}, row_idx_o, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    up_vld = 1'b1;
    p4_rdy = 1'b1;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    mem[10'h10] = 32'h04030201;
    mem[10'h11] = 32'h08070605;
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    start_layer(8'd2, 8'd3, 10'h10);
    check("basic_busy_c1", busy_o, 1);
    check("basic_rd_en_c1", parm_rd_en_o, 1);
    check("basic_addr_c1", parm_rd_addr_o, 10'h10);
    wait_done(40);
    check("basic_done_cnt", done_cnt - done_base, 1);
    check("basic_done_cyc", done_cyc, 11);
    check("basic_hs", hs_cnt - hs_base, 6);
    check("basic_rd_cnt", rd_q.size() - rd_base, 2);
    check("basic_rd0", rd_q[rd_base], 10'h10);
    check("basic_rd1", rd_q[rd_base + 1], 10'h11);
    check("basic_busy_end", busy_o, 0);
    check("basic_parm_hold", parm_bus, 32'h08070605);
    check("basic_idle_vld", p4_vld_o, 0);
    mem[10'h20] = 32'hA4A3A2A1;
    exp_w[0] = 32'hA4A3A2A1;
    p4_rdy = 1'b0;
    start_layer(8'd1, 8'd4, 10'h20);
    for (int i = 0; i < 60 && done_cnt == done_base; i++) begin
      p4_rdy = (i % 2 == 0);
      #1;
      if (p4_vld_o) begin
        check("bp_rdy_mirror", up_rdy_o, p4_rdy);
        check("bp_parm_stable", parm_bus, 32'hA4A3A2A1);
      end
      tick();
    end
    p4_rdy = 1'b1;
    check("bp_hs", hs_cnt - hs_base, 4);
    check("bp_done_cnt", done_cnt - done_base, 1);
    check("bp_rd_cnt", rd_q.size() - rd_base, 1);
    for (int k = 0; k < 2; k++) begin
      start_layer(k == 0 ? 8'd0 : 8'd2, k == 0 ? 8'd3 : 8'd0, 10'h30);
      check("zero_done", done_o, 1);
      check("zero_busy", busy_o, 1);
      check("zero_rd_en", parm_rd_en_o, 0);
      tick();
      check("zero_done_off", done_o, 0);
      check("zero_busy_off", busy_o, 0);
      check("zero_done_cnt", done_cnt - done_base, 1);
      check("zero_rd_cnt", rd_q.size() - rd_base, 0);
      check("zero_vld", vld_cnt - vld_base, 0);
    end
    mem[10'h30] = 32'h44332211;
    exp_w[0] = 32'h44332211;
    start_layer(8'd1, 8'd5, 10'h30);
    for (int i = 0; i < 20 && hs_cnt - hs_base < 2; i++) tick();
    check("abort_pre_row", row_idx_o, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_row", row_idx_o, 0);
    check("abort_grp", grp_idx_o, 0);
    check("abort_vld", p4_vld_o, 0);
    repeat (3) tick();
    check("abort_no_done", done_cnt - done_base, 0);
    mem[10'h40] = 32'h0D0C0B0A;
    exp_w[0] = 32'h0D0C0B0A;
    start_layer(8'd1, 8'd1, 10'h40);
    check("restart_grp", grp_idx_o, 0);
    check("restart_addr", parm_rd_addr_o, 10'h40);
    wait_done(20);
    check("restart_hs", hs_cnt - hs_base, 1);
    check("restart_done", done_cnt - done_base, 1);
    mem[10'h3FF] = 32'h5D5C5B5A;
    mem[10'h000] = 32'h01020304;
    exp_w[0] = 32'h5D5C5B5A;
    exp_w[1] = 32'h01020304;
    start_layer(8'd2, 8'd1, 10'h3FF);
    wait_done(30);
    check("wrap_rd0", rd_q[rd_base], 10'h3FF);
    check("wrap_rd1", rd_q[rd_base + 1], 10'h000);
    check("wrap_hs", hs_cnt - hs_base, 2);
    check("wrap_done", done_cnt - done_base, 1);
    mem[10'h50] = 32'h13121110;
    mem[10'h51] = 32'h17161514;
    exp_w[0] = 32'h13121110;
    exp_w[1] = 32'h17161514;
    start_layer(8'd2, 8'd2, 10'h50);
    tick();
    g = 8'd0;
    r = 8'd0;
    base = 10'h0;
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    wait_done(30);
    check("busy_start_hs", hs_cnt - hs_base, 4);
    check("busy_start_done", done_cnt - done_base, 1);
    check("busy_start_rd_cnt", rd_q.size() - rd_base, 2);
    check("busy_start_rd1", rd_q[rd_base + 1], 10'h51);
    mem[10'h60] = 32'h99887766;
    exp_w[0] = 32'h99887766;
    start_layer(8'd1, 8'd2, 10'h60);
    check("rstmid_rd_en", parm_rd_en_o, 1);
    rst = 1'b1;
    tick();
    chk_reset("rstmid");
    rst = 1'b0;
    repeat (4) tick();
    check("rstmid_vld", vld_cnt - vld_base, 0);
    check("rstmid_no_done", done_cnt - done_base, 0);
    check("rstmid_busy", busy_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
